// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the default-slave state type used by the
// response-side mux and its built-in error slave.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DS_IDLE = 2'b00,
      DS_ERR1 = 2'b01,
      DS_ERR2 = 2'b10
   } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: answers active transfers to disabled regions with
// the two-cycle AHB ERROR response (wait+ERROR, then ready+ERROR).
module ahb_default_slave
   import ahb_pkg::*;
(
   input  logic       hclk,
   input  logic       hresetn,
   input  logic       hready,
   input  logic [1:0] htrans,
   input  logic       unmapped,
   output logic       ds_hready,
   output logic       ds_hresp,
   output ds_state_t  ds_state
);

   ds_state_t state, state_next;
   logic      accept_err;

   // An unmapped NONSEQ/SEQ is accepted only when the bus is ready.
   assign accept_err = hready && htrans[1] && unmapped;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) state <= DS_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      ds_hready  = 1'b1;
      ds_hresp   = HRESP_OKAY;
      case (state)
         DS_IDLE: begin
            if (accept_err) state_next = DS_ERR1;
         end
         DS_ERR1: begin
            ds_hready  = 1'b0;
            ds_hresp   = HRESP_ERROR;
            state_next = DS_ERR2;
         end
         DS_ERR2: begin
            ds_hresp   = HRESP_ERROR;
            state_next = accept_err ? DS_ERR1 : DS_IDLE;
         end
         default: state_next = DS_IDLE;
      endcase
   end

   assign ds_state = state;

endmodule

// File: rtl/ahb_slave_mux.sv
// Response-side AHB mux: registers the decoder region in the address phase and
// steers the selected slave (or the default slave) back to the master.
module ahb_slave_mux
   import ahb_pkg::*;
#(
   parameter logic [3:0] REGION_EN = 4'b1111,
   parameter int         DW        = 32
) (
   input  logic          hclk,
   input  logic          hresetn,
   input  logic [1:0]    sel,
   input  logic          hsel_1,
   input  logic          hsel_2,
   input  logic          hsel_3,
   input  logic          hsel_4,
   input  logic [1:0]    htrans,
   output logic          hsel_1_o,
   output logic          hsel_2_o,
   output logic          hsel_3_o,
   output logic          hsel_4_o,
   input  logic [DW-1:0] hrdata_1,
   input  logic [DW-1:0] hrdata_2,
   input  logic [DW-1:0] hrdata_3,
   input  logic [DW-1:0] hrdata_4,
   input  logic          hreadyout_1,
   input  logic          hreadyout_2,
   input  logic          hreadyout_3,
   input  logic          hreadyout_4,
   input  logic          hresp_1,
   input  logic          hresp_2,
   input  logic          hresp_3,
   input  logic          hresp_4,
   output logic [DW-1:0] hrdata,
   output logic          hready,
   output logic          hresp
);

   logic [1:0]    dsel;
   logic          dact;
   logic          ds_hready, ds_hresp;
   ds_state_t     ds_state;
   logic [DW-1:0] rdata_a [4];
   logic [3:0]    rdy_a, resp_a;

   assign hsel_1_o = hsel_1 & REGION_EN[0];
   assign hsel_2_o = hsel_2 & REGION_EN[1];
   assign hsel_3_o = hsel_3 & REGION_EN[2];
   assign hsel_4_o = hsel_4 & REGION_EN[3];

   assign rdata_a[0] = hrdata_1;
   assign rdata_a[1] = hrdata_2;
   assign rdata_a[2] = hrdata_3;
   assign rdata_a[3] = hrdata_4;
   assign rdy_a      = {hreadyout_4, hreadyout_3, hreadyout_2, hreadyout_1};
   assign resp_a     = {hresp_4, hresp_3, hresp_2, hresp_1};

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         dsel <= 2'b00;
         dact <= 1'b0;
      end else if (hready) begin
         dsel <= sel;
         dact <= htrans[1];
      end
   end

   ahb_default_slave u_default_slave (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .hready    (hready),
      .htrans    (htrans),
      .unmapped  (!REGION_EN[sel]),
      .ds_hready (ds_hready),
      .ds_hresp  (ds_hresp),
      .ds_state  (ds_state)
   );

   // Only registered state feeds hready, so the hready->capture loop is broken.
   always_comb begin
      hrdata = '0;
      hready = ds_hready;
      hresp  = ds_hresp;
      if (REGION_EN[dsel]) begin
         hrdata = rdata_a[dsel];
         hready = rdy_a[dsel];
         hresp  = resp_a[dsel];
      end
      if (!hresetn) begin
         hready = 1'b1;
         hresp  = HRESP_OKAY;
      end
   end

   // The first error cycle can only follow an accepted active unmapped transfer.
   err1_origin: assert property (@(posedge hclk) disable iff (!hresetn)
      (ds_state == DS_ERR1) |-> (dact && !REGION_EN[dsel]));

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Bench for ahb_slave_mux: two instances (all regions enabled / region 4
// disabled) share stimulus and are checked against a transfer-level model.
module tb_ahb_slave_mux;

   localparam int DW = 32;
   localparam logic [3:0] EN_A = 4'b1111;
   localparam logic [3:0] EN_B = 4'b0111;

   logic          hclk = 1'b0;
   logic          hresetn = 1'b0;
   logic [1:0]    sel = 2'b00;
   logic [1:0]    htrans = 2'b00;
   logic [3:0]    hsel_i = 4'b0000;
   logic [DW-1:0] s_rdata [4];
   logic [3:0]    s_ready = 4'b1111;
   logic [3:0]    s_resp = 4'b0000;

   wire [3:0]     a_hsel_o, b_hsel_o;
   wire [DW-1:0]  a_hrdata, b_hrdata;
   wire           a_hready, b_hready, a_hresp, b_hresp;

   int n_checks = 0;
   int n_fail = 0;
   logic [DW+1:0] exp_q[$];

   // clock / reset
   always #5 hclk = ~hclk;

   ahb_slave_mux #(.REGION_EN(EN_A), .DW(DW)) dut_a (
      .hclk(hclk), .hresetn(hresetn), .sel(sel),
      .hsel_1(hsel_i[0]), .hsel_2(hsel_i[1]), .hsel_3(hsel_i[2]), .hsel_4(hsel_i[3]),
      .htrans(htrans),
      .hsel_1_o(a_hsel_o[0]), .hsel_2_o(a_hsel_o[1]), .hsel_3_o(a_hsel_o[2]), .hsel_4_o(a_hsel_o[3]),
      .hrdata_1(s_rdata[0]), .hrdata_2(s_rdata[1]), .hrdata_3(s_rdata[2]), .hrdata_4(s_rdata[3]),
      .hreadyout_1(s_ready[0]), .hreadyout_2(s_ready[1]), .hreadyout_3(s_ready[2]), .hreadyout_4(s_ready[3]),
      .hresp_1(s_resp[0]), .hresp_2(s_resp[1]), .hresp_3(s_resp[2]), .hresp_4(s_resp[3]),
      .hrdata(a_hrdata), .hready(a_hready), .hresp(a_hresp)
   );

   ahb_slave_mux #(.REGION_EN(EN_B), .DW(DW)) dut_b (
      .hclk(hclk), .hresetn(hresetn), .sel(sel),
      .hsel_1(hsel_i[0]), .hsel_2(hsel_i[1]), .hsel_3(hsel_i[2]), .hsel_4(hsel_i[3]),
      .htrans(htrans),
      .hsel_1_o(b_hsel_o[0]), .hsel_2_o(b_hsel_o[1]), .hsel_3_o(b_hsel_o[2]), .hsel_4_o(b_hsel_o[3]),
      .hrdata_1(s_rdata[0]), .hrdata_2(s_rdata[1]), .hrdata_3(s_rdata[2]), .hrdata_4(s_rdata[3]),
      .hreadyout_1(s_ready[0]), .hreadyout_2(s_ready[1]), .hreadyout_3(s_ready[2]), .hreadyout_4(s_ready[3]),
      .hresp_1(s_resp[0]), .hresp_2(s_resp[1]), .hresp_3(s_resp[2]), .hresp_4(s_resp[3]),
      .hrdata(b_hrdata), .hready(b_hready), .hresp(b_hresp)
   );

   // Transfer-level model: selected region per instance and the number of
   // error-response cycles still owed (2 = wait+ERROR next, 1 = final ERROR).
   logic [1:0] m_dsel [2];
   int         m_err  [2];

   function automatic logic [3:0] en_of(int d);
      return (d == 0) ? EN_A : EN_B;
   endfunction

   // Returns {hready, hresp, hrdata} the master must see from instance d.
   function automatic logic [DW+1:0] expect_out(int d);
      logic [3:0] en;
      en = en_of(d);
      if (!hresetn)
         return {1'b1, 1'b0, (en[0] ? s_rdata[0] : {DW{1'b0}})};
      if (en[m_dsel[d]])
         return {s_ready[m_dsel[d]], s_resp[m_dsel[d]], s_rdata[m_dsel[d]]};
      return {(m_err[d] != 2), (m_err[d] != 0), {DW{1'b0}}};
   endfunction

   always @(posedge hclk or negedge hresetn) begin
      for (int d = 0; d < 2; d++) begin
         logic [3:0]    en;
         logic [DW+1:0] e;
         en = en_of(d);
         if (!hresetn) begin
            m_dsel[d] = 2'b00;
            m_err[d]  = 0;
         end else begin
            e = expect_out(d);
            if (e[DW+1]) begin
               m_dsel[d] = sel;
               m_err[d]  = (htrans[1] && !en[sel]) ? 2 : 0;
            end else if (m_err[d] == 2) begin
               m_err[d] = 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every falling edge, both instances against the model.
   always @(negedge hclk) begin
      logic [DW+1:0] e;
      exp_q.push_back(expect_out(0));
      exp_q.push_back(expect_out(1));
      e = exp_q.pop_front();
      chk("a_hrdata", a_hrdata, e[DW-1:0]);
      chk("a_hready", {31'b0, a_hready}, {31'b0, e[DW+1]});
      chk("a_hresp",  {31'b0, a_hresp},  {31'b0, e[DW]});
      e = exp_q.pop_front();
      chk("b_hrdata", b_hrdata, e[DW-1:0]);
      chk("b_hready", {31'b0, b_hready}, {31'b0, e[DW+1]});
      chk("b_hresp",  {31'b0, b_hresp},  {31'b0, e[DW]});
      chk("a_hsel_o", {28'b0, a_hsel_o}, {28'b0, hsel_i & EN_A});
      chk("b_hsel_o", {28'b0, b_hsel_o}, {28'b0, hsel_i & EN_B});
   end

   // driver tasks
   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic addr(input logic [1:0] s, input logic [1:0] t);
      sel    = s;
      htrans = t;
      hsel_i = t[1] ? (4'b0001 << s) : 4'b0000;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) s_rdata[i] = 32'h0BAD_0000 + i;
      #2;
      settle();
      chk("rst_a_hready", {31'b0, a_hready}, 32'd1);
      chk("rst_a_hresp",  {31'b0, a_hresp},  32'd0);
      chk("rst_a_hrdata", a_hrdata, 32'h0BAD_0000);
      chk("rst_b_hrdata", b_hrdata, 32'h0BAD_0000);
      @(negedge hclk); #1 hresetn = 1'b1;

      // Single read to region 2.
      step();
      addr(2'b01, 2'b10);
      s_rdata[1] = 32'hA5A5_0001;
      step();
      addr(2'b00, 2'b00);
      settle();
      chk("t1_hrdata", a_hrdata, 32'hA5A5_0001);
      chk("t1_hready", {31'b0, a_hready}, 32'd1);
      chk("t1_hresp",  {31'b0, a_hresp},  32'd0);

      // Region 3 with two wait states while the next NONSEQ to region 1 waits.
      addr(2'b10, 2'b10);
      step();
      addr(2'b00, 2'b10);
      s_ready[2] = 1'b0;
      s_rdata[2] = 32'hC0DE_0003;
      s_rdata[0] = 32'h1111_0001;
      settle();
      chk("t2_wait1_hready", {31'b0, a_hready}, 32'd0);
      chk("t2_wait1_hrdata", a_hrdata, 32'hC0DE_0003);
      step();
      settle();
      chk("t2_wait2_hready", {31'b0, a_hready}, 32'd0);
      chk("t2_wait2_hrdata", a_hrdata, 32'hC0DE_0003);
      s_ready[2] = 1'b1;
      settle();
      chk("t2_done_hready", {31'b0, a_hready}, 32'd1);
      step();
      addr(2'b00, 2'b00);
      settle();
      chk("t2_next_hrdata", a_hrdata, 32'h1111_0001);

      // NONSEQ to disabled region 4 on instance b.
      addr(2'b11, 2'b10);
      settle();
      chk("t3_b_hsel4", {31'b0, b_hsel_o[3]}, 32'd0);
      chk("t3_a_hsel4", {31'b0, a_hsel_o[3]}, 32'd1);
      step();
      addr(2'b00, 2'b00);
      settle();
      chk("t3_err1", {30'b0, b_hready, b_hresp}, 32'b01);
      chk("t3_err1_data", b_hrdata, 32'h0);
      step();
      settle();
      chk("t3_err2", {30'b0, b_hready, b_hresp}, 32'b11);
      chk("t3_err2_data", b_hrdata, 32'h0);
      step();
      settle();
      chk("t3_idle", {30'b0, b_hready, b_hresp}, 32'b10);

      // Back-to-back errors: second transfer accepted during ERR2.
      addr(2'b11, 2'b10);
      step();
      settle();
      chk("t4_err1a", {30'b0, b_hready, b_hresp}, 32'b01);
      step();
      settle();
      chk("t4_err2a", {30'b0, b_hready, b_hresp}, 32'b11);
      step();
      addr(2'b00, 2'b00);
      settle();
      chk("t4_err1b", {30'b0, b_hready, b_hresp}, 32'b01);
      step();
      settle();
      chk("t4_err2b", {30'b0, b_hready, b_hresp}, 32'b11);

      // IDLE to disabled region stays OKAY.
      addr(2'b11, 2'b00);
      step();
      settle();
      chk("t5_idle_okay", {30'b0, b_hready, b_hresp}, 32'b10);
      step();
      settle();
      chk("t5_still_idle", {30'b0, b_hready, b_hresp}, 32'b10);

      // Asynchronous reset in the middle of ERR1.
      addr(2'b11, 2'b10);
      step();
      addr(2'b00, 2'b00);
      settle();
      chk("t6_err1", {30'b0, b_hready, b_hresp}, 32'b01);
      #1 hresetn = 1'b0;
      settle();
      chk("t6_rst_now", {30'b0, b_hready, b_hresp}, 32'b10);
      @(negedge hclk); #1 hresetn = 1'b1;
      step();
      addr(2'b00, 2'b10);
      s_rdata[0] = 32'h5A5A_0006;
      step();
      addr(2'b00, 2'b00);
      settle();
      chk("t6_after_rst_data", b_hrdata, 32'h5A5A_0006);
      chk("t6_after_rst_resp", {30'b0, b_hready, b_hresp}, 32'b10);

      // Randomized traffic with occasional asynchronous resets.
      repeat (1500) begin
         step();
         if (!hresetn) hresetn = 1'b1;
         sel    = 2'($urandom_range(0, 3));
         htrans = 2'($urandom_range(0, 3));
         hsel_i = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) begin
            s_rdata[i] = $urandom;
            s_ready[i] = ($urandom_range(0, 3) != 0);
            s_resp[i]  = ($urandom_range(0, 7) == 0);
         end
         if ($urandom_range(0, 99) == 0) begin
            #2 hresetn = 1'b0;
         end
      end
      step();
      hresetn = 1'b1;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
